lhn_input_port: RTL and testbench
=================================

LHN_INPUT_PORT -- requirements
Module: lhn_input_port

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 4, number of consecutive stable synchronized samples needed to accept a button level change (range 2..255).
REQ-002 Parameter: FIFO_DEPTH, default 4, number of entries in the event FIFO (power of 2, range 2..16).
REQ-003 Clock_pin  input  1  single clock; all state updates on the rising edge.
REQ-004 Resetn_pin  input  1  reset, asynchronous assert, active-low.
REQ-005 SW_pin  input  5  bits 3:0 are data switches; bit 4 is the push-button; all bits asynchronous to Clock_pin.
REQ-006 rd_en  input  1  CPU IN-instruction pop strobe, one cycle per pop.
REQ-007 IPDR_out  output  14  head FIFO word, feeds the CPU input data register.
REQ-008 empty  output  1  FIFO holds 0 entries.
REQ-009 full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-010 count  output  5  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 ovf  output  1  sticky flag: a press event was dropped.

Function
REQ-012 All five SW_pin bits shall pass through a 2-flop synchronizer before any other use.
REQ-013 The button FSM shall have states IDLE (released), PRESS_CHK, HELD, REL_CHK.
REQ-014 IDLE->PRESS_CHK on a synchronized button 1; the run counter loads 1.
REQ-015 In PRESS_CHK, each further 1 increments the counter; a 0 returns to IDLE and clears the counter; when the counter reaches DEBOUNCE_CYCLES the FSM enters HELD and a press event fires.
REQ-016 HELD->REL_CHK on a synchronized 0; REL_CHK mirrors PRESS_CHK with polarity inverted and returns to IDLE after DEBOUNCE_CYCLES consecutive 0s; a 1 returns to HELD. No event fires on release.
REQ-017 Each press event shall push the word {6'b0, seq[3:0], sw_sync[3:0]}: seq is a 4-bit press counter that increments on every press event, including dropped ones, and wraps 15->0. sw_sync is the synchronized switches on the event cycle.
REQ-018 The FIFO shall be first-word-fall-through: IPDR_out equals the head entry while empty=0, and 14'h0000 while empty=1.
REQ-019 A pushed word shall be visible on IPDR_out and empty shall fall on the clock edge following the event.
REQ-020 rd_en with empty=0 shall pop one entry on that edge. rd_en with empty=1 shall be ignored with no state change.
REQ-021 Push with full=1 and no pop: the word is dropped, count is unchanged, and ovf is set.
REQ-022 Simultaneous push and pop: at full, the pop is applied first and then the push is accepted, with count unchanged. At empty, only the push takes effect.
REQ-023 ovf shall clear on an accepted pop, unless a drop occurs on the same edge, in which case ovf stays set.
REQ-024 Read and write pointers shall wrap modulo FIFO_DEPTH.

Reset
REQ-025 When Resetn_pin=0, the following shall apply immediately regardless of clock: FSM=IDLE, counter=0, seq=0, pointers=0, count=0, empty=1, full=0, ovf=0, IPDR_out=14'h0000, and synchronizer flops=0.
REQ-026 Reset asserted mid-debounce or with FIFO contents shall discard all state. After release, a button still held shall re-qualify from IDLE.

Configuration
REQ-027 Macro LHN_INPUT_PORT_DEBOUNCE_EN, when defined, shall select the FSM behaviour in REQ-013..016.
REQ-028 When LHN_INPUT_PORT_DEBOUNCE_EN is undefined: PRESS_CHK and REL_CHK are removed, IDLE->HELD on the first synchronized 1 with an event, HELD->IDLE on the first synchronized 0, DEBOUNCE_CYCLES is unused, and all other requirements hold.

Verification
REQ-029 DEBOUNCE_EN defined, DEBOUNCE_CYCLES=4, SW_pin=5'b0_1010, then bit 4 raised and held: empty falls exactly 2+4+1 edges after the first edge sampling bit 4 high, and IPDR_out=14'h000A.
REQ-030 Bit 4 pulsed high for 3 cycles, low for 1, then high for 3, repeated: no event, and empty stays 1.
REQ-031 Five clean presses with SW=4'h3 and no reads: full=1 after the 4th press, the 5th press is dropped, ovf=1, and IPDR_out=14'h0003. Reads then return 0x0003, 0x0013, 0x0023, 0x0033; the 6th press returns 0x0053.
REQ-032 With full=1, rd_en coincides with a press event: count stays 4, ovf is unchanged, and the new word is at the tail.
REQ-033 With empty=1, rd_en pulsed: count=0, IPDR_out=0, and no pointer movement. Resetn_pin dropped mid-PRESS_CHK with 2 entries stored: all outputs match reset values asynchronously.
REQ-034 DEBOUNCE_EN undefined: a single-cycle button high after synchronization yields exactly one event, 3 edges after the pin sample.

Source files
------------

// File: rtl/lhn_input_port.sv
// Switch/push-button input port: 2-flop synchronizer, button press qualifier and FWFT event FIFO.
// Define LHN_INPUT_PORT_DEBOUNCE_EN to qualify press/release over DEBOUNCE_CYCLES stable samples.
module lhn_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        Clock_pin,
  input  logic        Resetn_pin,
  input  logic [4:0]  SW_pin,
  input  logic        rd_en,
  output logic [13:0] IPDR_out,
  output logic        empty,
  output logic        full,
  output logic [4:0]  count,
  output logic        ovf
);

  localparam int unsigned SW_W  = 5;
  localparam int unsigned WD_W  = 14;
  localparam int unsigned CNT_W = 5;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned RUN_W = 8;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be in 2..255");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 in 2..16");
  end

`ifdef LHN_INPUT_PORT_DEBOUNCE_EN
  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} btn_state_e;
`else
  typedef enum logic [1:0] {IDLE, HELD} btn_state_e;
`endif

  logic [SW_W-1:0]  sync1_q, sync1_d, sync2_q, sync2_d;
  btn_state_e       state_q, state_d;
  logic             event_q, event_d;
  logic [3:0]       seq_q, seq_d;
  logic [WD_W-1:0]  mem_q [FIFO_DEPTH];
  logic [WD_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_q, empty_d, full_q, full_d, ovf_q, ovf_d;
  logic [WD_W-1:0]  ipdr_q, ipdr_d;
  logic             btn;
`ifdef LHN_INPUT_PORT_DEBOUNCE_EN
  logic [RUN_W-1:0] run_q, run_d, run_inc;
`endif

  assign btn = sync2_q[4];

  // Two-stage synchronizer on every pin before any other use.
  always_comb begin
    sync1_d = SW_pin;
    sync2_d = sync1_q;
  end

  // Button qualifier; a press event is registered and pushed on the following edge.
  always_comb begin
    state_d = state_q;
    event_d = 1'b0;
`ifdef LHN_INPUT_PORT_DEBOUNCE_EN
    run_d   = run_q;
    run_inc = RUN_W'(run_q + 8'd1);
    case (state_q)
      IDLE: begin
        if (btn) begin
          state_d = PRESS_CHK;
          run_d   = 8'd1;
        end
      end
      PRESS_CHK: begin
        if (!btn) begin
          state_d = IDLE;
          run_d   = '0;
        end else if (run_inc == RUN_W'(DEBOUNCE_CYCLES)) begin
          state_d = HELD;
          run_d   = '0;
          event_d = 1'b1;
        end else begin
          run_d = run_inc;
        end
      end
      HELD: begin
        if (!btn) begin
          state_d = REL_CHK;
          run_d   = 8'd1;
        end
      end
      REL_CHK: begin
        if (btn) begin
          state_d = HELD;
          run_d   = '0;
        end else if (run_inc == RUN_W'(DEBOUNCE_CYCLES)) begin
          state_d = IDLE;
          run_d   = '0;
        end else begin
          run_d = run_inc;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = '0;
      end
    endcase
`else
    case (state_q)
      IDLE: begin
        if (btn) begin
          state_d = HELD;
          event_d = 1'b1;
        end
      end
      HELD: begin
        if (!btn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`endif
  end

  // Event FIFO: pop before push so a full FIFO can accept a push on a popping edge.
  always_comb begin
    logic push, pop, push_ok, drop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    seq_d    = seq_q;
    push     = event_q;
    pop      = rd_en & ~empty_q;
    push_ok  = push & (~full_q | pop);
    drop     = push & full_q & ~pop;

    if (push) seq_d = 4'(seq_q + 4'd1);
    if (pop) rd_ptr_d = PTR_W'(rd_ptr_q + 1'b1);
    if (push_ok) begin
      mem_d[wr_ptr_q] = {6'b0, seq_q, sync2_q[3:0]};
      wr_ptr_d        = PTR_W'(wr_ptr_q + 1'b1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = CNT_W'(count_q + 5'd1);
      2'b01:   count_d = CNT_W'(count_q - 5'd1);
      default: count_d = count_q;
    endcase
    if (pop)  ovf_d = 1'b0;
    if (drop) ovf_d = 1'b1;

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    ipdr_d  = empty_d ? '0 : mem_d[rd_ptr_d];
  end

  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      state_q  <= IDLE;
      event_q  <= 1'b0;
      seq_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ipdr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      state_q  <= state_d;
      event_q  <= event_d;
      seq_q    <= seq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      ipdr_q   <= ipdr_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef LHN_INPUT_PORT_DEBOUNCE_EN
  always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
    if (!Resetn_pin) run_q <= '0;
    else             run_q <= run_d;
  end
`endif

  assign IPDR_out = ipdr_q;
  assign empty    = empty_q;
  assign full     = full_q;
  assign count    = count_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_lhn_input_port.sv
// Scoreboard bench for lhn_input_port; expected words are queued at each press and compared at the FIFO head.
module tb_lhn_input_port;

  localparam int unsigned DEB   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef LHN_INPUT_PORT_DEBOUNCE_EN
  localparam int unsigned LAT = 2 + DEB + 1;
`else
  localparam int unsigned LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  sw;
  logic        rd_en;
  logic [13:0] ipdr;
  logic        empty, full, ovf;
  logic [4:0]  count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [13:0] sb_q[$];
  logic [3:0]  m_seq;
  logic        m_ovf;

  lhn_input_port #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .Clock_pin (clk),
    .Resetn_pin(rst_n),
    .SW_pin    (sw),
    .rd_en     (rd_en),
    .IPDR_out  (ipdr),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_push(input logic [3:0] d);
    if (sb_q.size() < DEPTH) sb_q.push_back({6'b0, m_seq, d});
    else m_ovf = 1'b1;
    m_seq = m_seq + 4'd1;
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_seq = '0;
    m_ovf = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [13:0] head;
    head = (sb_q.size() != 0) ? sb_q[0] : 14'h0000;
    check({tag, ".count"}, 32'(count), 32'(sb_q.size()));
    check({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
    check({tag, ".full"},  32'(full),  32'(sb_q.size() == DEPTH));
    check({tag, ".ovf"},   32'(ovf),   32'(m_ovf));
    check({tag, ".ipdr"},  32'(ipdr),  32'(head));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Clean press and release; called and returns on a falling edge.
  task automatic press(input logic [3:0] d);
    sw = {1'b1, d};
    repeat (LAT + 2) @(negedge clk);
    sw = {1'b0, d};
    repeat (LAT + 2) @(negedge clk);
    model_push(d);
  endtask

  task automatic pop(input string tag);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (sb_q.size() != 0) begin
      void'(sb_q.pop_front());
      m_ovf = 1'b0;
    end
    check_state(tag);
  endtask

  // Count rising edges until empty falls; button already raised on the preceding falling edge.
  task automatic measure_latency(input string tag, input bit single_pulse);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (single_pulse && n == 1) sw[4] = 1'b0;
    end while (empty && n < 40);
    check(tag, 32'(n), 32'(LAT));
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    sw    = '0;
    rd_en = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Latency of the first press and its data word.
    sw = 5'b0_1010;
    repeat (2) @(negedge clk);
    sw = 5'b1_1010;
`ifdef LHN_INPUT_PORT_DEBOUNCE_EN
    measure_latency("press_latency", 1'b0);
`else
    measure_latency("press_latency", 1'b1);
`endif
    check("first_word", 32'(ipdr), 32'h000A);
    model_push(4'hA);
    sw = 5'b0_1010;
    repeat (LAT + 2) @(negedge clk);
    check_state("one_event");
    pop("pop_first");

    // Pop request while empty is ignored.
    pop("pop_empty");
    press(4'h5);
    check_state("after_empty_pop");
    pop("pop_after_empty");

    // Fill, overflow, drain.
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      press(4'h3);
      check_state($sformatf("fill%0d", i));
      if (i == 3) check("full_at_4", 32'(full), 32'h1);
    end
    check("ovf_set", 32'(ovf), 32'h1);
    check("head_after_ovf", 32'(ipdr), 32'h0003);
    for (int i = 0; i < 4; i++) pop($sformatf("drain%0d", i));

`ifdef LHN_INPUT_PORT_DEBOUNCE_EN
    // 3-high/1-low bounce never qualifies.
    for (int r = 0; r < 4; r++) begin
      sw = 5'b1_0011;
      repeat (3) @(negedge clk);
      sw = 5'b0_0011;
      @(negedge clk);
    end
    repeat (LAT + 4) @(negedge clk);
    check_state("bounce");
`endif

    press(4'h3);
    check("sixth_press", 32'(ipdr), 32'h0053);
    check_state("sixth");

    // Push and pop on the same edge while full.
    press(4'h3);
    press(4'h3);
    press(4'h3);
    check_state("refill");
    sw = 5'b1_1100;
    repeat (LAT - 1) @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    void'(sb_q.pop_front());
    m_ovf = 1'b0;
    model_push(4'hC);
    check("full_pushpop_count", 32'(count), 32'd4);
    check_state("full_pushpop");
    sw = 5'b0_1100;
    repeat (LAT + 2) @(negedge clk);
    for (int i = 0; i < 4; i++) pop($sformatf("tail%0d", i));

    // Asynchronous reset mid-qualification with two entries stored.
    press(4'h1);
    press(4'h2);
    check_state("two_stored");
    sw = 5'b1_0111;
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst.count", 32'(count), 32'h0);
    check("async_rst.empty", 32'(empty), 32'h1);
    check("async_rst.full",  32'(full),  32'h0);
    check("async_rst.ovf",   32'(ovf),   32'h0);
    check("async_rst.ipdr",  32'(ipdr),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    measure_latency("requalify_latency", 1'b0);
    model_push(4'h7);
    check_state("requalify");
    sw = 5'b0_0111;
    repeat (LAT + 2) @(negedge clk);
    pop("final_pop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
